spi_slave_responder: RTL and testbench
======================================

Name: spi_slave_responder

Overview:
RTL SPI slave (responder) that forms the other end of the SPI master link modelled by the verification environment. It oversamples sclk/cs_n/mosi on the system clock, supports all four CPOL/CPHA modes and both shift directions, and shifts CHAR_LENGTH-bit characters in both directions. A single-entry TX holding register and a single-entry RX holding register give the core valid/ready handshakes. It is the DUT-side counterpart used to close the loop with the AVIP master agent.

Parameters:
CHAR_LENGTH, 8, bits per character (legal 4..32)
NO_OF_SLAVES, 1, width of the chip-select bus seen on the link; this instance responds to cs_n[CS_INDEX]
CS_INDEX, 0, selected chip-select bit (0..NO_OF_SLAVES-1)

Ports:
pclk  input  1  system clock
areset  input  1  synchronous active-high reset
cfg_mode  input  2  {CPOL,CPHA}: 00/01/10/11 match CPOL0_CPHA0..CPOL1_CPHA1; sampled only in IDLE
cfg_msb_first  input  1  1 = MSB_FIRST, 0 = LSB_FIRST; sampled only in IDLE
sclk  input  1  SPI serial clock (asynchronous to pclk)
cs_n  input  NO_OF_SLAVES  active-low chip selects
mosi  input  1  master-out data
miso  output  1  slave-out data
miso_oe  output  1  miso output enable (tristate control at pad)
tx_data  input  CHAR_LENGTH  next character to send
tx_valid  input  1  tx_data valid
tx_ready  output  1  TX holding register empty
rx_data  output  CHAR_LENGTH  received character
rx_valid  output  1  rx_data valid
rx_ready  input  1  consumer accepts rx_data
busy  output  1  chip select active (state != IDLE)

Behaviour:
- Reset (areset high at pclk edge): state IDLE; miso=0, miso_oe=0, tx_ready=1, rx_valid=0, rx_data=0, busy=0; synchronisers cleared to idle levels (cs_n=1, sclk=CPOL of cfg_mode).
- Inputs pass through 2-flop synchronisers; edge detect adds 1 cycle. sclk high and low phases must each be >=4 pclk cycles; shorter phases are unsupported.
- Leading edge = transition away from CPOL; trailing = return to CPOL. CPHA=0: sample on leading, shift on trailing. CPHA=1: shift on leading, sample on trailing.
- TX handshake: transfer when tx_valid && tx_ready; holding register loads and tx_ready drops next cycle. tx_ready returns to 1 in the cycle the holding register moves into the shift register.
- States:
  - IDLE: on synced cs_n falling, latch cfg and go to LOAD.
  - LOAD (1 cycle): shift register <= holding register if full, else all zeros (underrun); miso_oe=1. CPHA=0 drives the first bit on miso here; go to SHIFT.
  - SHIFT: bit counter 0..CHAR_LENGTH-1; each sample edge captures mosi into the RX shifter (MSB- or LSB-first per cfg). After sample CHAR_LENGTH, go to DONE. CPHA=1 drives the first bit on the first leading edge.
  - DONE (1 cycle): push RX char; if cs_n still low, reload as in LOAD and return to SHIFT (back-to-back chars); else go to IDLE.
- RX push: if rx_valid=0 or rx_ready=1 in that cycle, rx_data <= char and rx_valid=1. Otherwise overrun: the new char is dropped and the old one is kept. rx_valid clears on rx_valid && rx_ready with no simultaneous push.
- cs_n rising in any non-IDLE state: the partial RX char is discarded, the partial TX char is lost (not retried), miso_oe=0 next cycle, state goes to IDLE.
- miso=0 whenever miso_oe=0.
- cfg changes while busy are ignored until the next IDLE.

Optional Feature:
SPI_SLAVE_STATUS_EN: adds outputs overrun_flag, underrun_flag (sticky, 1 bit each) and input status_clr (1 bit).
- overrun_flag sets on a dropped RX char.
- underrun_flag sets when LOAD/DONE finds the TX holding register empty.
- Both clear on status_clr or reset; set has priority over clear in the same cycle.
- Without the macro these ports do not exist, and overrun/underrun are silent (drop/zero-fill only).

Test Plan:
- Mode 00, MSB first, tx_data=0xA5 preloaded; master sends 0x3C -> miso bits 1,0,1,0,0,1,0,1; rx_data=0x3C, rx_valid=1; tx_ready=1 after LOAD.
- Mode 11, LSB first, tx=0x81, master sends 0x0F -> miso LSB-first 1,0,0,0,0,0,0,1 shifted on leading edges; rx_data=0x0F.
- Back-to-back: cs_n low for 2 chars, tx 0x11 then 0x22 queued in time, rx_ready=1 -> rx 2 chars in order; miso carries 0x11 then 0x22.
- Overrun: rx_ready=0, send 0x55 then 0xAA -> rx_data stays 0x55; overrun_flag=1 with macro; status_clr clears it.
- Underrun: no tx_valid, master sends 0xFF -> miso all 0; underrun_flag=1 with macro; rx_data=0xFF.
- Abort: cs_n raised after 3 bits, then a full char 0x99 -> no rx_valid for the partial char, rx_data=0x99 afterwards. areset mid-char returns every output to its reset value.

Source files
------------

// File: rtl/spi_slave_responder.sv
// SPI slave (responder): oversamples sclk/cs_n/mosi on pclk, supports all
// four CPOL/CPHA modes and both shift directions. TX and RX each have a
// single-entry holding register with a valid/ready handshake.
// Optional macro SPI_SLAVE_STATUS_EN adds sticky overrun/underrun flags
// and a status_clr input.
module spi_slave_responder #(
    parameter int CHAR_LENGTH  = 8,
    parameter int NO_OF_SLAVES = 1,
    parameter int CS_INDEX     = 0
) (
    input  logic                    pclk,
    input  logic                    areset,
    input  logic [1:0]              cfg_mode,
    input  logic                    cfg_msb_first,
    input  logic                    sclk,
    input  logic [NO_OF_SLAVES-1:0] cs_n,
    input  logic                    mosi,
    output logic                    miso,
    output logic                    miso_oe,
    input  logic [CHAR_LENGTH-1:0]  tx_data,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    output logic [CHAR_LENGTH-1:0]  rx_data,
    output logic                    rx_valid,
    input  logic                    rx_ready,
`ifdef SPI_SLAVE_STATUS_EN
    input  logic                    status_clr,
    output logic                    overrun_flag,
    output logic                    underrun_flag,
`endif
    output logic                    busy
);

    localparam int CNT_W = $clog2(CHAR_LENGTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAR_LENGTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t state, state_next;

    logic [1:0]             sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_d, cs_d;
    logic                   cfg_cpol, cfg_cpha, cfg_msb;
    logic [CHAR_LENGTH-1:0] hold, tx_sr, rx_sr;
    logic                   hold_full;
    logic                   miso_r;
    logic                   armed;
    logic [CNT_W-1:0]       bit_cnt;

    logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
    logic cs_fall, cs_high;
    logic latch_cfg, take, push, sample, drive;
    logic [CHAR_LENGTH-1:0] load_val;

    function automatic logic first_bit(input logic [CHAR_LENGTH-1:0] v, input logic msb);
        return msb ? v[CHAR_LENGTH-1] : v[0];
    endfunction

    function automatic logic [CHAR_LENGTH-1:0] shift_out(input logic [CHAR_LENGTH-1:0] v,
                                                         input logic msb);
        return msb ? {v[CHAR_LENGTH-2:0], 1'b0} : {1'b0, v[CHAR_LENGTH-1:1]};
    endfunction

    // Two-flop synchronisers plus one delay stage for edge detection.
    always_ff @(posedge pclk) begin
        if (areset) begin
            sclk_sync <= {2{cfg_mode[1]}};
            sclk_d    <= cfg_mode[1];
            cs_sync   <= '1;
            cs_d      <= 1'b1;
            mosi_sync <= '0;
        end else begin
            sclk_sync <= {sclk_sync[0], sclk};
            sclk_d    <= sclk_sync[1];
            cs_sync   <= {cs_sync[0], cs_n[CS_INDEX]};
            cs_d      <= cs_sync[1];
            mosi_sync <= {mosi_sync[0], mosi};
        end
    end

    assign sclk_rise   = sclk_sync[1] & ~sclk_d;
    assign sclk_fall   = ~sclk_sync[1] & sclk_d;
    assign lead_edge   = cfg_cpol ? sclk_fall : sclk_rise;
    assign trail_edge  = cfg_cpol ? sclk_rise : sclk_fall;
    assign sample_edge = cfg_cpha ? trail_edge : lead_edge;
    assign shift_edge  = cfg_cpha ? lead_edge : trail_edge;
    assign cs_fall     = cs_d & ~cs_sync[1];
    assign cs_high     = cs_sync[1];
    assign load_val    = hold_full ? hold : '0;

    // State register.
    always_ff @(posedge pclk) begin
        if (areset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        state_next = state;
        latch_cfg  = 1'b0;
        take       = 1'b0;
        push       = 1'b0;
        sample     = 1'b0;
        drive      = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    latch_cfg  = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (cs_high) begin
                    state_next = IDLE;
                end else begin
                    take       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_high) begin
                    state_next = IDLE;
                end else begin
                    if (sample_edge) begin
                        sample = 1'b1;
                        if (bit_cnt == LAST_BIT) state_next = DONE;
                    end
                    // With CPHA=0 the trailing edge that closes the last bit of a
                    // character arrives after the next character was already
                    // loaded; 'armed' suppresses that stale shift.
                    if (shift_edge && (cfg_cpha || armed)) drive = 1'b1;
                end
            end
            DONE: begin
                push = 1'b1;
                if (cs_high) begin
                    state_next = IDLE;
                end else begin
                    take       = 1'b1;
                    state_next = SHIFT;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Latched configuration, shift registers, bit counter and miso driver.
    always_ff @(posedge pclk) begin
        if (areset) begin
            cfg_cpol <= cfg_mode[1];
            cfg_cpha <= 1'b0;
            cfg_msb  <= 1'b0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            miso_r   <= 1'b0;
            armed    <= 1'b0;
            bit_cnt  <= '0;
        end else begin
            if (latch_cfg) begin
                cfg_cpol <= cfg_mode[1];
                cfg_cpha <= cfg_mode[0];
                cfg_msb  <= cfg_msb_first;
            end
            if (take) begin
                armed   <= 1'b0;
                bit_cnt <= '0;
                if (cfg_cpha) begin
                    tx_sr <= load_val;
                end else begin
                    miso_r <= first_bit(load_val, cfg_msb);
                    tx_sr  <= shift_out(load_val, cfg_msb);
                end
            end
            if (drive) begin
                armed  <= 1'b0;
                miso_r <= first_bit(tx_sr, cfg_msb);
                tx_sr  <= shift_out(tx_sr, cfg_msb);
            end
            if (sample) begin
                armed   <= 1'b1;
                bit_cnt <= bit_cnt + CNT_W'(1);
                rx_sr   <= cfg_msb ? {rx_sr[CHAR_LENGTH-2:0], mosi_sync[1]}
                                   : {mosi_sync[1], rx_sr[CHAR_LENGTH-1:1]};
            end
        end
    end

    // TX holding register: accepts when empty, empties when moved to tx_sr.
    always_ff @(posedge pclk) begin
        if (areset) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (take && hold_full) begin
            hold_full <= 1'b0;
        end else if (tx_valid && !hold_full) begin
            hold      <= tx_data;
            hold_full <= 1'b1;
        end
    end

    // RX holding register: push unless full and not being drained (overrun).
    always_ff @(posedge pclk) begin
        if (areset) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else if (push && (!rx_valid || rx_ready)) begin
            rx_data  <= rx_sr;
            rx_valid <= 1'b1;
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
        end
    end

`ifdef SPI_SLAVE_STATUS_EN
    // Sticky status flags; a new event wins over a same-cycle clear.
    always_ff @(posedge pclk) begin
        if (areset) begin
            overrun_flag  <= 1'b0;
            underrun_flag <= 1'b0;
        end else begin
            overrun_flag  <= (push && rx_valid && !rx_ready) || (overrun_flag && !status_clr);
            underrun_flag <= (take && !hold_full) || (underrun_flag && !status_clr);
        end
    end
`endif

    assign tx_ready = ~hold_full;
    assign miso_oe  = (state != IDLE);
    assign busy     = (state != IDLE);
    assign miso     = miso_oe & miso_r;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder: a table of single-character
// transfers followed by hand-written back-to-back, overrun, abort and
// reset sequences. The bench acts as the SPI master with 6-cycle phases.
module tb_spi_slave_responder;

    localparam int H = 6;

    logic       pclk = 1'b0;
    logic       areset;
    logic [1:0] cfg_mode;
    logic       cfg_msb_first;
    logic       sclk;
    logic [0:0] cs_n;
    logic       mosi;
    logic       miso, miso_oe;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready;
    logic       busy;
`ifdef SPI_SLAVE_STATUS_EN
    logic       status_clr;
    logic       overrun_flag, underrun_flag;
`endif

    int errs   = 0;
    int checks = 0;
    logic [7:0] rx_log[$];

    always #5 pclk = ~pclk;

    spi_slave_responder #(
        .CHAR_LENGTH(8),
        .NO_OF_SLAVES(1),
        .CS_INDEX(0)
    ) dut (
        .pclk(pclk),
        .areset(areset),
        .cfg_mode(cfg_mode),
        .cfg_msb_first(cfg_msb_first),
        .sclk(sclk),
        .cs_n(cs_n),
        .mosi(mosi),
        .miso(miso),
        .miso_oe(miso_oe),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
`ifdef SPI_SLAVE_STATUS_EN
        .status_clr(status_clr),
        .overrun_flag(overrun_flag),
        .underrun_flag(underrun_flag),
`endif
        .busy(busy)
    );

    // Log every character the consumer accepts.
    always @(posedge pclk) begin
        if (!areset && rx_valid && rx_ready) rx_log.push_back(rx_data);
    end

    typedef struct {
        logic [1:0] mode;
        logic       msb;
        logic       use_tx;
        logic [7:0] tx;
        logic [7:0] mosi_v;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int unsigned n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic set_mode(input logic [1:0] m, input logic msb);
        @(negedge pclk);
        cfg_mode      = m;
        cfg_msb_first = msb;
        sclk          = m[1];
        wait_cyc(4);
    endtask

    task automatic push_tx(input logic [7:0] v);
        @(negedge pclk);
        tx_data  = v;
        tx_valid = 1'b1;
        @(negedge pclk);
        tx_valid = 1'b0;
    endtask

    task automatic cs_start();
        @(negedge pclk);
        cs_n = 1'b0;
        wait_cyc(8);
    endtask

    task automatic cs_end();
        @(negedge pclk);
        cs_n = 1'b1;
        wait_cyc(8);
    endtask

    // Master side of n bits: drives mosi, toggles sclk, captures miso.
    task automatic bits(input logic [7:0] v, input int unsigned n, output logic [7:0] got);
        logic cpol, cpha;
        cpol = cfg_mode[1];
        cpha = cfg_mode[0];
        got  = '0;
        for (int unsigned i = 0; i < n; i++) begin
            int unsigned idx;
            idx = cfg_msb_first ? 7 - i : i;
            if (!cpha) begin
                mosi = v[idx];
                wait_cyc(H);
                sclk = ~cpol;
                got[idx] = miso;
                wait_cyc(H);
                sclk = cpol;
            end else begin
                sclk = ~cpol;
                mosi = v[idx];
                wait_cyc(H);
                sclk = cpol;
                got[idx] = miso;
                wait_cyc(H);
            end
        end
        wait_cyc(H);
    endtask

    task automatic xfer(input logic [7:0] v, output logic [7:0] got);
        cs_start();
        bits(v, 8, got);
        cs_end();
    endtask

    task automatic drain_rx();
        @(negedge pclk);
        rx_ready = 1'b1;
        @(negedge pclk);
        rx_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] g, g1, g2;

        vecs[0] = '{mode: 2'b00, msb: 1'b1, use_tx: 1'b1, tx: 8'hA5, mosi_v: 8'h3C, exp_miso: 8'hA5, exp_rx: 8'h3C};
        vecs[1] = '{mode: 2'b11, msb: 1'b0, use_tx: 1'b1, tx: 8'h81, mosi_v: 8'h0F, exp_miso: 8'h81, exp_rx: 8'h0F};
        vecs[2] = '{mode: 2'b01, msb: 1'b1, use_tx: 1'b1, tx: 8'hC3, mosi_v: 8'h5A, exp_miso: 8'hC3, exp_rx: 8'h5A};
        vecs[3] = '{mode: 2'b10, msb: 1'b0, use_tx: 1'b1, tx: 8'h6E, mosi_v: 8'h96, exp_miso: 8'h6E, exp_rx: 8'h96};
        vecs[4] = '{mode: 2'b00, msb: 1'b1, use_tx: 1'b0, tx: 8'h00, mosi_v: 8'hFF, exp_miso: 8'h00, exp_rx: 8'hFF};

        areset        = 1'b1;
        cfg_mode      = 2'b00;
        cfg_msb_first = 1'b1;
        sclk          = 1'b0;
        cs_n          = 1'b1;
        mosi          = 1'b0;
        tx_data       = '0;
        tx_valid      = 1'b0;
        rx_ready      = 1'b0;
`ifdef SPI_SLAVE_STATUS_EN
        status_clr    = 1'b0;
`endif
        wait_cyc(4);
        areset = 1'b0;
        wait_cyc(2);

        chk("reset_miso", miso, 0);
        chk("reset_miso_oe", miso_oe, 0);
        chk("reset_tx_ready", tx_ready, 1);
        chk("reset_rx_valid", rx_valid, 0);
        chk("reset_rx_data", rx_data, 0);
        chk("reset_busy", busy, 0);

        for (int unsigned k = 0; k < 5; k++) begin
            set_mode(vecs[k].mode, vecs[k].msb);
            if (vecs[k].use_tx) begin
                push_tx(vecs[k].tx);
                chk("tx_ready_full", tx_ready, 0);
            end
            cs_start();
            chk("tx_ready_after_load", tx_ready, 1);
            chk("busy_active", busy, 1);
            bits(vecs[k].mosi_v, 8, g);
            cs_end();
            chk("miso_char", g, vecs[k].exp_miso);
            chk("rx_valid", rx_valid, 1);
            chk("rx_data", rx_data, vecs[k].exp_rx);
            chk("busy_idle", busy, 0);
            chk("miso_oe_idle", miso_oe, 0);
            drain_rx();
            chk("rx_valid_drained", rx_valid, 0);
        end

`ifdef SPI_SLAVE_STATUS_EN
        chk("underrun_flag", underrun_flag, 1);
        @(negedge pclk);
        status_clr = 1'b1;
        @(negedge pclk);
        status_clr = 1'b0;
        chk("underrun_cleared", underrun_flag, 0);
`endif

        // Back-to-back characters under one chip select.
        set_mode(2'b00, 1'b1);
        push_tx(8'h11);
        cs_start();
        push_tx(8'h22);
        rx_log.delete();
        rx_ready = 1'b1;
        bits(8'hA1, 8, g1);
        bits(8'h3B, 8, g2);
        cs_end();
        rx_ready = 1'b0;
        chk("b2b_miso_1", g1, 8'h11);
        chk("b2b_miso_2", g2, 8'h22);
        chk("b2b_rx_count", rx_log.size(), 2);
        if (rx_log.size() == 2) begin
            chk("b2b_rx_1", rx_log[0], 8'hA1);
            chk("b2b_rx_2", rx_log[1], 8'h3B);
        end

        // Overrun: second character dropped while the first is unread.
        xfer(8'h55, g);
        xfer(8'hAA, g);
        chk("overrun_rx_valid", rx_valid, 1);
        chk("overrun_rx_data", rx_data, 8'h55);
`ifdef SPI_SLAVE_STATUS_EN
        chk("overrun_flag", overrun_flag, 1);
        @(negedge pclk);
        status_clr = 1'b1;
        @(negedge pclk);
        status_clr = 1'b0;
        chk("overrun_cleared", overrun_flag, 0);
`endif
        drain_rx();

        // Abort after three bits, then a full character.
        set_mode(2'b01, 1'b1);
        cs_start();
        bits(8'hE7, 3, g);
        cs_end();
        chk("abort_rx_valid", rx_valid, 0);
        chk("abort_busy", busy, 0);
        xfer(8'h99, g);
        chk("after_abort_rx_valid", rx_valid, 1);
        chk("after_abort_rx_data", rx_data, 8'h99);

        // Reset in the middle of a character with TX held and RX full.
        set_mode(2'b00, 1'b1);
        cs_start();
        push_tx(8'h77);
        chk("pre_reset_tx_ready", tx_ready, 0);
        bits(8'hF0, 4, g);
        chk("pre_reset_busy", busy, 1);
        @(negedge pclk);
        areset = 1'b1;
        @(negedge pclk);
        chk("mid_reset_miso", miso, 0);
        chk("mid_reset_miso_oe", miso_oe, 0);
        chk("mid_reset_tx_ready", tx_ready, 1);
        chk("mid_reset_rx_valid", rx_valid, 0);
        chk("mid_reset_rx_data", rx_data, 0);
        chk("mid_reset_busy", busy, 0);
        cs_n = 1'b1;
        sclk = cfg_mode[1];
        wait_cyc(3);
        areset = 1'b0;
        wait_cyc(6);
        chk("post_reset_busy", busy, 0);
        chk("post_reset_rx_valid", rx_valid, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
